// File: rtl/dht11_uart_sender.sv
// Formats each DHT11 {temperature, humidity} result as an ASCII line and sends it out as 8N1 UART.
// A zero result is the reader's checksum error code and becomes "ERR\r\n".
module dht11_uart_sender #(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample_valid,
   input  logic [15:0] sample_data,
   output logic        tx,
   output logic        busy,
   output logic        sample_drop
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0] BYTE_LAST_NORMAL = 4'd12;
   localparam logic [3:0] BYTE_LAST_ERROR  = 4'd4;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [3:0]       byte_q, byte_d;
   logic [1:0][11:0] dig_q, dig_d;
   logic [1:0][11:0] dig_now;
   logic             err_q, err_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             drop_q, drop_d;
   logic             baud_end;
   logic [3:0]       byte_last;
   logic [7:0]       cur_byte;

   // Field 0 is humidity, field 1 temperature; each packed as {hundreds, tens, ones}.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bcd
         logic [7:0] val;
         assign val             = sample_data[8*gi +: 8];
         assign dig_now[gi][11:8] = 4'(val / 8'd100);
         assign dig_now[gi][7:4]  = 4'((val / 8'd10) % 8'd10);
         assign dig_now[gi][3:0]  = 4'(val % 8'd10);
      end
   endgenerate

   assign baud_end  = (baud_q == BAUD_LAST);
   assign byte_last = err_q ? BYTE_LAST_ERROR : BYTE_LAST_NORMAL;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      dig_d   = dig_q;
      err_d   = err_q;
      drop_d  = sample_valid & busy_q;
      case (state_q)
         IDLE: begin
            if (sample_valid) begin
               state_d = START;
               baud_d  = '0;
               bit_d   = '0;
               byte_d  = '0;
               dig_d   = dig_now;
               err_d   = (sample_data == 16'h0000);
            end
         end
         START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (byte_q == byte_last) begin
                  state_d = IDLE;
               end else begin
                  byte_d  = byte_q + 4'd1;
                  state_d = START;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // Byte mux looks at the next index so tx can be registered without a cycle of lag.
   always_comb begin
      cur_byte = 8'h0A;
      case (byte_d)
         4'd0:  cur_byte = err_q ? 8'h45 : 8'h54;
         4'd1:  cur_byte = err_q ? 8'h52 : 8'h3D;
         4'd2:  cur_byte = err_q ? 8'h52 : {4'h3, dig_q[1][11:8]};
         4'd3:  cur_byte = err_q ? 8'h0D : {4'h3, dig_q[1][7:4]};
         4'd4:  cur_byte = err_q ? 8'h0A : {4'h3, dig_q[1][3:0]};
         4'd5:  cur_byte = 8'h20;
         4'd6:  cur_byte = 8'h48;
         4'd7:  cur_byte = 8'h3D;
         4'd8:  cur_byte = {4'h3, dig_q[0][11:8]};
         4'd9:  cur_byte = {4'h3, dig_q[0][7:4]};
         4'd10: cur_byte = {4'h3, dig_q[0][3:0]};
         4'd11: cur_byte = 8'h0D;
         default: cur_byte = 8'h0A;
      endcase
   end

   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = cur_byte[bit_d];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         dig_q   <= '0;
         err_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         dig_q   <= dig_d;
         err_q   <= err_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         drop_q  <= drop_d;
      end
   end

   assign tx          = tx_q;
   assign busy        = busy_q;
   assign sample_drop = drop_q;

endmodule

// File: tb/tb_dht11_uart_sender.sv
// Randomized bench for dht11_uart_sender: a UART receiver monitor decodes tx and checks every
// byte against lines predicted from the sample values with string formatting.
module tb_dht11_uart_sender;

   localparam int CLK_FREQ = 1000;
   localparam int BAUD     = 100;
   localparam int CPB      = CLK_FREQ / BAUD;

   logic        clk = 1'b0;
   logic        rst;
   logic        sample_valid;
   logic [15:0] sample_data;
   logic        tx;
   logic        busy;
   logic        sample_drop;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int drop_seen = 0;

   logic [7:0] exp_q[$];
   bit         last_q[$];

   dht11_uart_sender #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD(BAUD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sample_valid(sample_valid),
      .sample_data(sample_data),
      .tx(tx),
      .busy(busy),
      .sample_drop(sample_drop)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end else begin
         $display("[TB] ok   %s: %0d at cycle %0d", name, act, cyc);
      end
   endtask

   function automatic string line_for(input logic [15:0] d);
      if (d == 16'h0000) return "ERR\r\n";
      return $sformatf("T=%03d H=%03d\r\n", d[15:8], d[7:0]);
   endfunction

   function automatic int busy_len_for(input logic [15:0] d);
      string s = line_for(d);
      return s.len() * 10 * CPB;
   endfunction

   task automatic push_line(input logic [15:0] d);
      string s = line_for(d);
      for (int i = 0; i < s.len(); i++) begin
         exp_q.push_back(s[i]);
         last_q.push_back(i == s.len() - 1);
      end
   endtask

   // Called at a negedge; the strobe is sampled on the following posedge.
   task automatic strobe(input logic [15:0] d, input bit accept);
      sample_valid = 1'b1;
      sample_data  = d;
      if (accept) push_line(d);
      @(negedge clk);
      sample_valid = 1'b0;
      sample_data  = 16'($urandom);
      if (accept) begin
         check("start_latency_tx", int'(tx), 0);
         check("busy_rise", int'(busy), 1);
      end
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 5000) begin
         n++;
         @(negedge clk);
      end
      if (n >= 5000) check("busy_timeout", n, 0);
   endtask

   // UART receiver: mid-bit sampling, stop-bit and inter-byte gap checks.
   initial begin
      int         rx_cnt;
      int         prev_start;
      bit         expect_cont;
      logic [7:0] rx_sh;
      logic [7:0] e;
      bit         l;
      rx_cnt = -1;
      prev_start = 0;
      expect_cont = 1'b0;
      rx_sh = '0;
      forever begin
         @(negedge clk);
         if (sample_drop === 1'b1) drop_seen++;
         if (rst === 1'b1) begin
            rx_cnt = -1;
            expect_cont = 1'b0;
            exp_q.delete();
            last_q.delete();
         end else if (rx_cnt < 0) begin
            if (tx === 1'b0) begin
               rx_cnt = 0;
               if (expect_cont) check("byte_gap", cyc - prev_start, 10 * CPB);
               prev_start = cyc;
            end
         end else begin
            rx_cnt++;
            if (rx_cnt == CPB / 2) begin
               check("start_bit_mid", int'(tx), 0);
            end else if (rx_cnt >= CPB + CPB / 2 && rx_cnt <= 8 * CPB + CPB / 2 &&
                         (rx_cnt - CPB / 2) % CPB == 0) begin
               rx_sh[(rx_cnt - CPB / 2) / CPB - 1] = tx;
            end else if (rx_cnt == 9 * CPB + CPB / 2) begin
               check("stop_bit", int'(tx), 1);
               if (exp_q.size() == 0) begin
                  check("unexpected_byte", int'(rx_sh), -1);
               end else begin
                  e = exp_q.pop_front();
                  l = last_q.pop_front();
                  check("rx_byte", int'(rx_sh), int'(e));
                  expect_cont = !l;
               end
               rx_cnt = -1;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: simulation exceeded time limit, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int m;
      int bad;
      logic [15:0] d;
      logic [15:0] directed [3];
      directed[0] = 16'h1928;
      directed[1] = 16'hFF00;
      directed[2] = 16'h0000;

      rst = 1'b1;
      sample_valid = 1'b0;
      sample_data = 16'h0000;
      repeat (3) @(negedge clk);
      check("reset_tx", int'(tx), 1);
      check("reset_busy", int'(busy), 0);
      check("reset_drop", int'(sample_drop), 0);
      rst = 1'b0;

      bad = 0;
      repeat (500) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || sample_drop !== 1'b0) bad++;
      end
      check("idle_quiet_cycles_bad", bad, 0);

      foreach (directed[i]) begin
         strobe(directed[i], 1'b1);
         wait_idle(n);
         check("busy_len", n, busy_len_for(directed[i]));
         repeat (3) @(negedge clk);
      end

      // Strobe mid-line is dropped with a single-cycle pulse.
      strobe(16'h1928, 1'b1);
      repeat (598) @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = 16'h0A0A;
      @(negedge clk);
      sample_valid = 1'b0;
      check("drop_pulse", int'(sample_drop), 1);
      @(negedge clk);
      check("drop_width", int'(sample_drop), 0);
      wait_idle(n);
      check("busy_len_with_drop", n + 600, 1300);

      // Strobe in the first idle cycle is accepted immediately.
      strobe(16'h1928, 1'b1);
      wait_idle(n);
      check("busy_len", n, 1300);
      strobe(16'h0A0A, 1'b1);
      wait_idle(n);
      check("busy_len_back_to_back", n, 1300);
      repeat (5) @(negedge clk);

      // Strobe in the final stop-bit cycle is dropped, not queued.
      strobe(16'h3344, 1'b1);
      m = 1;
      while (m < 1300 && busy === 1'b1) begin
         @(negedge clk);
         m++;
      end
      check("busy_last_cycle", int'(busy), 1);
      sample_valid = 1'b1;
      sample_data  = 16'h5A5A;
      @(negedge clk);
      sample_valid = 1'b0;
      check("busy_fall", int'(busy), 0);
      check("final_stop_drop", int'(sample_drop), 1);
      @(negedge clk);
      check("final_drop_not_accepted_tx", int'(tx), 1);
      check("final_drop_not_accepted_busy", int'(busy), 0);
      repeat (5) @(negedge clk);

      // Reset mid-line abandons the line.
      strobe(16'h1928, 1'b1);
      repeat (698) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midline_rst_tx", int'(tx), 1);
      check("midline_rst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      strobe(16'h0119, 1'b1);
      wait_idle(n);
      check("busy_len_after_rst", n, 1300);

      // Randomized back-to-back lines, including one forced error code.
      for (int i = 0; i < 6; i++) begin
         d = (i == 2) ? 16'h0000 : 16'($urandom);
         strobe(d, 1'b1);
         wait_idle(n);
         check("busy_len_random", n, busy_len_for(d));
      end

      m = 0;
      while (exp_q.size() != 0 && m < 2000) begin
         @(negedge clk);
         m++;
      end
      check("queue_drained", exp_q.size(), 0);
      check("drop_count", drop_seen, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
